victim_buffer: RTL and testbench
================================

VICTIM_BUFFER -- requirements
Module: victim_buffer

Interface
REQ-001 Parameter ENTRY_NUM, default 4, SHALL set the number of fully-associative entries (power of two, minimum 2).
REQ-002 Parameter TAG_WIDTH, default 20, SHALL set the line tag width.
REQ-003 Parameter INDEX_WIDTH, default 6, SHALL set the set-index width.
REQ-004 Parameter LINE_WORD_NUM, default 16, SHALL set the number of 32-bit words per line.
REQ-005 Ports SHALL be, in order:
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- lookup_valid  in  1  lookup request
- lookup_ready  out  1  lookup accepted
- lookup_tag  in  TAG_WIDTH  lookup tag
- lookup_index  in  INDEX_WIDTH  lookup index
- lookup_take  in  1  invalidate entry on hit
- resp_valid  out  1  lookup result valid
- resp_hit  out  1  lookup hit
- resp_dirty  out  1  dirty bit of the hit entry
- resp_data  out  LINE_WORD_NUM x 32  hit line data
- ins_valid  in  1  insert request
- ins_ready  out  1  insert accepted
- ins_tag  in  TAG_WIDTH  insert tag
- ins_index  in  INDEX_WIDTH  insert index
- ins_dirty  in  1  insert dirty bit
- ins_data  in  LINE_WORD_NUM x 32  insert line data
- wb_valid  out  1  dirty eviction pending
- wb_ready  in  1  eviction accepted downstream
- wb_tag  out  TAG_WIDTH  evicted tag
- wb_index  out  INDEX_WIDTH  evicted index
- wb_data  out  LINE_WORD_NUM x 32  evicted line data
- occupancy  out  clog2(ENTRY_NUM)+1  count of valid entries

Function
REQ-006 Each entry SHALL hold valid, dirty, tag, index and line data, and a hit SHALL require valid together with tag and index equality.
REQ-007 The controller SHALL have two states, IDLE and WB; lookup_ready and ins_ready SHALL be 1 only in IDLE.
REQ-008 A lookup accepted in cycle N SHALL produce registered resp_valid=1 in cycle N+1, along with resp_hit, resp_dirty and resp_data; on a miss resp_data and resp_dirty SHALL be 0.
REQ-009 An accepted lookup that hits with lookup_take=1 SHALL clear that entry's valid bit at the cycle-N edge.
REQ-010 An accepted insert whose tag and index match a valid entry SHALL overwrite that entry's data, with dirty updated to old dirty OR ins_dirty; no eviction SHALL occur.
REQ-011 Otherwise, if any entry is invalid, the insert SHALL write the lowest-numbered invalid entry.
REQ-012 Otherwise the insert SHALL target the entry at the round-robin pointer rr_ptr:
- victim clean: overwrite it in the same cycle and increment rr_ptr, wrapping from ENTRY_NUM-1 to 0;
- victim dirty: latch the insert payload and move to WB.
REQ-013 In WB, wb_valid SHALL be 1 and wb_* SHALL show the victim, stable until wb_ready=1.
REQ-014 On wb_ready=1 in WB, the latched insert SHALL be written into the victim slot, rr_ptr SHALL increment, and the state SHALL return to IDLE; wb_valid SHALL be 0 in the next cycle.
REQ-015 When a lookup and an insert are accepted in the same cycle, the lookup SHALL see the pre-insert contents.
REQ-016 If a take-hit and an insert target the same entry in the same cycle, the insert SHALL win and the entry SHALL remain valid.
REQ-017 occupancy SHALL equal the number of valid entries after each edge.

Reset
REQ-018 When rst=1 at a clk edge, all valid and dirty bits, rr_ptr and occupancy SHALL become 0, and the state SHALL become IDLE.
REQ-019 During and after reset, resp_valid, resp_hit, resp_dirty, resp_data, wb_valid and wb_* SHALL be 0.
REQ-020 A reset asserted in WB SHALL discard both the latched insert and the pending eviction.
REQ-021 Line data storage SHALL need no reset.

Configuration
REQ-022 With VICTIM_PERF_CNT_EN defined, the block SHALL add 32-bit outputs perf_hit_cnt, perf_miss_cnt and perf_wb_cnt:
- counts of hit responses, miss responses and completed dirty evictions;
- reset to 0 and saturate at 0xFFFFFFFF.
REQ-023 Without VICTIM_PERF_CNT_EN, these ports and their counters SHALL be absent.

Verification
REQ-024 Insert tag 0x12345 / index 0x05 / clean, then look up the same with take=0 -> next cycle resp_hit=1, data matches, occupancy=1.
REQ-025 Repeat the lookup with take=1, then look up again -> first hit=1, second hit=0, occupancy=0.
REQ-026 Fill 4 clean entries, then insert a 5th -> entry 0 replaced with no wb_valid, rr_ptr=1, occupancy=4.
REQ-027 Fill 4 entries with entry 0 dirty, insert a 5th, and hold wb_ready=0 for 3 cycles -> wb_valid=1 with entry 0's tag/index/data stable and ins_ready=0; then wb_ready=1 -> new line in slot 0, IDLE the next cycle.
REQ-028 Re-insert an existing tag/index with ins_dirty=1 -> occupancy unchanged, resp_dirty=1 on the next lookup.
REQ-029 Assert rst while in WB -> wb_valid=0, occupancy=0, and all lookups miss.

Source files
------------

// File: rtl/victim_buffer.sv
// victim_buffer: fully-associative victim cache with round-robin replacement and dirty write-back.
// Define VICTIM_PERF_CNT_EN to add saturating hit/miss/write-back counters (perf_*_cnt ports).
module victim_buffer #(
    parameter int ENTRY_NUM     = 4,
    parameter int TAG_WIDTH     = 20,
    parameter int INDEX_WIDTH   = 6,
    parameter int LINE_WORD_NUM = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           lookup_valid,
    output logic                           lookup_ready,
    input  logic [TAG_WIDTH-1:0]           lookup_tag,
    input  logic [INDEX_WIDTH-1:0]         lookup_index,
    input  logic                           lookup_take,
    output logic                           resp_valid,
    output logic                           resp_hit,
    output logic                           resp_dirty,
    output logic [LINE_WORD_NUM*32-1:0]    resp_data,
    input  logic                           ins_valid,
    output logic                           ins_ready,
    input  logic [TAG_WIDTH-1:0]           ins_tag,
    input  logic [INDEX_WIDTH-1:0]         ins_index,
    input  logic                           ins_dirty,
    input  logic [LINE_WORD_NUM*32-1:0]    ins_data,
    output logic                           wb_valid,
    input  logic                           wb_ready,
    output logic [TAG_WIDTH-1:0]           wb_tag,
    output logic [INDEX_WIDTH-1:0]         wb_index,
    output logic [LINE_WORD_NUM*32-1:0]    wb_data,
    output logic [$clog2(ENTRY_NUM):0]     occupancy
`ifdef VICTIM_PERF_CNT_EN
    ,
    output logic [31:0]                    perf_hit_cnt,
    output logic [31:0]                    perf_miss_cnt,
    output logic [31:0]                    perf_wb_cnt
`endif
);
    localparam int PW = $clog2(ENTRY_NUM);
    localparam int OW = PW + 1;
    localparam int DW = LINE_WORD_NUM * 32;

    typedef enum logic {IDLE, WB} state_t;
    state_t state;

    logic [ENTRY_NUM-1:0]   valid, dirty;
    logic [TAG_WIDTH-1:0]   tags  [ENTRY_NUM];
    logic [INDEX_WIDTH-1:0] idxs  [ENTRY_NUM];
    logic [DW-1:0]          datas [ENTRY_NUM];
    logic [PW-1:0]          rr_ptr;

    logic [TAG_WIDTH-1:0]   pend_tag;
    logic [INDEX_WIDTH-1:0] pend_index;
    logic                   pend_dirty;
    logic [DW-1:0]          pend_data;

    logic          lk_hit, ins_match, any_free;
    logic [PW-1:0] lk_sel, ins_sel, free_sel, ins_tgt, wr_sel;
    logic          in_wb, evict, lk_fire, ins_fire, wb_done, wr_en, wr_dirty, rr_inc;

    // Associative search; descending scan so the lowest-numbered match/free slot wins
    always_comb begin
        lk_hit    = 1'b0;
        lk_sel    = '0;
        ins_match = 1'b0;
        ins_sel   = '0;
        any_free  = 1'b0;
        free_sel  = '0;
        occupancy = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == lookup_tag && idxs[i] == lookup_index) begin
                lk_hit = 1'b1;
                lk_sel = PW'(i);
            end
            if (valid[i] && tags[i] == ins_tag && idxs[i] == ins_index) begin
                ins_match = 1'b1;
                ins_sel   = PW'(i);
            end
            if (!valid[i]) begin
                any_free = 1'b1;
                free_sel = PW'(i);
            end
            occupancy = occupancy + OW'(valid[i]);
        end
    end

    // Insert targeting, handshakes and the write-back view of the victim slot
    always_comb begin
        in_wb        = state == WB;
        lookup_ready = !in_wb;
        ins_ready    = !in_wb;
        lk_fire      = lookup_valid && !in_wb;
        ins_fire     = ins_valid && !in_wb;
        wb_done      = in_wb && wb_ready;
        ins_tgt      = ins_match ? ins_sel : any_free ? free_sel : rr_ptr;
        evict        = !ins_match && !any_free && dirty[rr_ptr];
        wr_en        = (ins_fire && !evict) || wb_done;
        wr_sel       = in_wb ? rr_ptr : ins_tgt;
        wr_dirty     = in_wb ? pend_dirty : (ins_match && dirty[ins_sel]) || ins_dirty;
        rr_inc       = wb_done || (ins_fire && !ins_match && !any_free && !evict);
        wb_valid     = in_wb;
        wb_tag       = in_wb ? tags[rr_ptr] : '0;
        wb_index     = in_wb ? idxs[rr_ptr] : '0;
        wb_data      = in_wb ? datas[rr_ptr] : '0;
    end

    // Control state: valid/dirty bits, replacement pointer, FSM and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_dirty <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= lk_fire;
            resp_hit   <= lk_fire && lk_hit;
            resp_dirty <= lk_fire && lk_hit && dirty[lk_sel];
            resp_data  <= (lk_fire && lk_hit) ? datas[lk_sel] : '0;
            if (lk_fire && lk_hit && lookup_take)
                valid[lk_sel] <= 1'b0;
            if (wr_en) begin
                valid[wr_sel] <= 1'b1;
                dirty[wr_sel] <= wr_dirty;
            end
            if (rr_inc)
                rr_ptr <= rr_ptr + PW'(1);
            if (ins_fire && evict)
                state <= WB;
            else if (wb_done)
                state <= IDLE;
        end
    end

    // Line storage and parked insert payload; contents are qualified by valid/state so no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_sel]  <= in_wb ? pend_tag : ins_tag;
            idxs[wr_sel]  <= in_wb ? pend_index : ins_index;
            datas[wr_sel] <= in_wb ? pend_data : ins_data;
        end
        if (ins_fire && evict) begin
            pend_tag   <= ins_tag;
            pend_index <= ins_index;
            pend_dirty <= ins_dirty;
            pend_data  <= ins_data;
        end
    end

`ifdef VICTIM_PERF_CNT_EN
    // Saturating event counters for hits, misses and completed dirty evictions
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
            perf_wb_cnt   <= '0;
        end else begin
            if (lk_fire && lk_hit && ~&perf_hit_cnt)
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            if (lk_fire && !lk_hit && ~&perf_miss_cnt)
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
            if (wb_done && ~&perf_wb_cnt)
                perf_wb_cnt <= perf_wb_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_victim_buffer.sv
// tb_victim_buffer: directed stimulus with a response scoreboard for victim_buffer.
module tb_victim_buffer;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lookup_valid = 1'b0, lookup_ready, lookup_take = 1'b0;
    logic [19:0]   lookup_tag = '0;
    logic [5:0]    lookup_index = '0;
    logic          resp_valid, resp_hit, resp_dirty;
    logic [DW-1:0] resp_data;
    logic          ins_valid = 1'b0, ins_ready, ins_dirty = 1'b0;
    logic [19:0]   ins_tag = '0;
    logic [5:0]    ins_index = '0;
    logic [DW-1:0] ins_data = '0;
    logic          wb_valid, wb_ready = 1'b0;
    logic [19:0]   wb_tag;
    logic [5:0]    wb_index;
    logic [DW-1:0] wb_data;
    logic [2:0]    occupancy;

    always #5 clk = ~clk;

    victim_buffer dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_tag(lookup_tag),
        .lookup_index(lookup_index), .lookup_take(lookup_take),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_dirty(resp_dirty), .resp_data(resp_data),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_tag(ins_tag), .ins_index(ins_index),
        .ins_dirty(ins_dirty), .ins_data(ins_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_index(wb_index), .wb_data(wb_data),
        .occupancy(occupancy)
    );

    typedef struct {
        logic          hit;
        logic          dirty;
        logic [DW-1:0] data;
    } exp_t;
    exp_t q[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] ln(input logic [31:0] s);
        for (int w = 0; w < 16; w++) ln[w*32 +: 32] = s + 32'(w) * 32'h0101_0101;
    endfunction

    // Response monitor: every presented response must match the oldest queued expectation
    always @(negedge clk) begin
        if (resp_valid) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_hit", DW'(resp_hit), DW'(e.hit));
                chk("resp_dirty", DW'(resp_dirty), DW'(e.dirty));
                chk("resp_data", resp_data, e.data);
            end
        end
    end

    task automatic arm_lk(input logic [19:0] t, input logic [5:0] i, input logic take,
                          input logic h, input logic d, input logic [DW-1:0] data);
        lookup_valid = 1'b1;
        lookup_tag   = t;
        lookup_index = i;
        lookup_take  = take;
        q.push_back('{hit: h, dirty: d, data: data});
    endtask

    task automatic arm_ins(input logic [19:0] t, input logic [5:0] i, input logic d, input logic [DW-1:0] data);
        ins_valid = 1'b1;
        ins_tag   = t;
        ins_index = i;
        ins_dirty = d;
        ins_data  = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        lookup_take  = 1'b0;
        ins_valid    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_occupancy", DW'(occupancy), DW'(0));
        chk("rst_resp_valid", DW'(resp_valid), DW'(0));
        chk("rst_resp_data", resp_data, '0);
        chk("rst_wb_valid", DW'(wb_valid), DW'(0));
        chk("rst_wb_data", wb_data, '0);
        chk("rst_ins_ready", DW'(ins_ready), DW'(1));
        chk("rst_lookup_ready", DW'(lookup_ready), DW'(1));

        // single insert then non-destructive hit
        arm_ins(20'h12345, 6'h05, 1'b0, ln(32'hA000_0000)); step();
        chk("ins1_occupancy", DW'(occupancy), DW'(1));
        arm_lk(20'h12345, 6'h05, 1'b0, 1'b1, 1'b0, ln(32'hA000_0000)); step();
        chk("lk1_occupancy", DW'(occupancy), DW'(1));
        // take-hit, then miss
        arm_lk(20'h12345, 6'h05, 1'b1, 1'b1, 1'b0, ln(32'hA000_0000)); step();
        arm_lk(20'h12345, 6'h05, 1'b0, 1'b0, 1'b0, '0); step();
        chk("take_occupancy", DW'(occupancy), DW'(0));
        // wrong index on same tag must miss
        arm_ins(20'h12345, 6'h05, 1'b0, ln(32'hA000_0000)); step();
        arm_lk(20'h12345, 6'h06, 1'b0, 1'b0, 1'b0, '0); step();
        arm_lk(20'h12345, 6'h05, 1'b1, 1'b1, 1'b0, ln(32'hA000_0000)); step();

        // fill four clean entries, then clean round-robin replacements
        for (int k = 0; k < 4; k++) begin
            arm_ins(20'h100 + 20'(k), 6'(k), 1'b0, ln(32'h100 + 32'(k))); step();
        end
        chk("fill_occupancy", DW'(occupancy), DW'(4));
        arm_ins(20'h200, 6'd9, 1'b0, ln(32'h200)); step();
        chk("clean_evict_wb_valid", DW'(wb_valid), DW'(0));
        chk("clean_evict_occupancy", DW'(occupancy), DW'(4));
        chk("clean_evict_ins_ready", DW'(ins_ready), DW'(1));
        arm_lk(20'h100, 6'd0, 1'b0, 1'b0, 1'b0, '0); step();
        arm_lk(20'h200, 6'd9, 1'b0, 1'b1, 1'b0, ln(32'h200)); step();
        arm_ins(20'h201, 6'd9, 1'b0, ln(32'h201)); step();
        arm_lk(20'h101, 6'd1, 1'b0, 1'b0, 1'b0, '0); step();
        arm_lk(20'h102, 6'd2, 1'b0, 1'b1, 1'b0, ln(32'h102)); step();

        // re-insert existing line as dirty: merged in place
        arm_ins(20'h102, 6'd2, 1'b1, ln(32'h8102)); step();
        chk("merge_occupancy", DW'(occupancy), DW'(4));
        chk("merge_wb_valid", DW'(wb_valid), DW'(0));
        arm_lk(20'h102, 6'd2, 1'b0, 1'b1, 1'b1, ln(32'h8102)); step();
        // clean re-insert keeps the dirty bit
        arm_ins(20'h102, 6'd2, 1'b0, ln(32'h9102)); step();
        arm_lk(20'h102, 6'd2, 1'b0, 1'b1, 1'b1, ln(32'h9102)); step();

        // dirty victim: entry 0 dirty, insert a fifth line, hold wb_ready low
        do_reset();
        arm_ins(20'h300, 6'd0, 1'b1, ln(32'h300)); step();
        for (int k = 1; k < 4; k++) begin
            arm_ins(20'h300 + 20'(k), 6'(k), 1'b0, ln(32'h300 + 32'(k))); step();
        end
        arm_ins(20'h400, 6'h3F, 1'b0, ln(32'h400)); step();
        lookup_valid = 1'b1; lookup_tag = 20'h301; lookup_index = 6'd1; lookup_take = 1'b1;
        arm_ins(20'h777, 6'd7, 1'b1, ln(32'h777));
        for (int k = 0; k < 3; k++) begin
            chk("wb_hold_valid", DW'(wb_valid), DW'(1));
            chk("wb_hold_tag", DW'(wb_tag), DW'(20'h300));
            chk("wb_hold_index", DW'(wb_index), DW'(0));
            chk("wb_hold_data", wb_data, ln(32'h300));
            chk("wb_hold_ins_ready", DW'(ins_ready), DW'(0));
            chk("wb_hold_lookup_ready", DW'(lookup_ready), DW'(0));
            @(posedge clk); #1;
        end
        lookup_valid = 1'b0; lookup_take = 1'b0; ins_valid = 1'b0;
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready = 1'b0;
        chk("wb_done_valid", DW'(wb_valid), DW'(0));
        chk("wb_done_ins_ready", DW'(ins_ready), DW'(1));
        chk("wb_done_occupancy", DW'(occupancy), DW'(4));
        arm_lk(20'h400, 6'h3F, 1'b0, 1'b1, 1'b0, ln(32'h400)); step();
        arm_lk(20'h300, 6'd0, 1'b0, 1'b0, 1'b0, '0); step();
        arm_lk(20'h301, 6'd1, 1'b0, 1'b1, 1'b0, ln(32'h301)); step();
        arm_lk(20'h777, 6'd7, 1'b0, 1'b0, 1'b0, '0); step();

        // same-cycle take-hit and insert to one entry: lookup sees old, insert wins
        arm_lk(20'h302, 6'd2, 1'b1, 1'b1, 1'b0, ln(32'h302));
        arm_ins(20'h302, 6'd2, 1'b1, ln(32'h9302)); step();
        chk("collide_occupancy", DW'(occupancy), DW'(4));
        arm_lk(20'h302, 6'd2, 1'b0, 1'b1, 1'b1, ln(32'h9302)); step();

        // enter write-back on the dirty slot 2, then reset mid write-back
        arm_ins(20'h500, 6'd9, 1'b0, ln(32'h500)); step();
        chk("rr_clean_wb_valid", DW'(wb_valid), DW'(0));
        arm_ins(20'h501, 6'd9, 1'b0, ln(32'h501)); step();
        chk("wb2_valid", DW'(wb_valid), DW'(1));
        chk("wb2_tag", DW'(wb_tag), DW'(20'h302));
        chk("wb2_index", DW'(wb_index), DW'(2));
        chk("wb2_data", wb_data, ln(32'h9302));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("wbrst_wb_valid", DW'(wb_valid), DW'(0));
        chk("wbrst_wb_tag", DW'(wb_tag), DW'(0));
        chk("wbrst_wb_data", wb_data, '0);
        chk("wbrst_occupancy", DW'(occupancy), DW'(0));
        chk("wbrst_ins_ready", DW'(ins_ready), DW'(1));
        arm_lk(20'h501, 6'd9, 1'b0, 1'b0, 1'b0, '0); step();
        arm_lk(20'h302, 6'd2, 1'b0, 1'b0, 1'b0, '0); step();
        arm_lk(20'h400, 6'h3F, 1'b0, 1'b0, 1'b0, '0); step();
        arm_lk(20'h500, 6'd9, 1'b0, 1'b0, 1'b0, '0); step();
        chk("wbrst_final_occupancy", DW'(occupancy), DW'(0));

        repeat (3) @(posedge clk);
        #1;
        chk("resp_queue_drained", DW'(q.size()), DW'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
